// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; waits for data_sram responses and aligns load data; `MS_LOAD_FWD_EN forwards load data once it arrives
module mem_stage (
  input  logic         clk,
  input  logic         resetn,
  input  logic         es_to_ms_valid,
  input  logic [177:0] es_to_ms_bus,
  output logic         ms_allowin,
  input  logic         ws_allowin,
  output logic         ms_to_ws_valid,
  output logic [171:0] ms_to_ws_bus,
  input  logic         data_sram_data_ok,
  input  logic [31:0]  data_sram_rdata,
  output logic [31:0]  data_sram_addr_error,
  input  logic         wb_ex,
  input  logic         wb_ertn,
  output logic         ms_ex,
  output logic [40:0]  ms_fwd_bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t state, state_nx;
  logic [176:0] bus_r;
  logic ms_valid, cancel, buf_valid;
  logic [31:0] buf_data;
  logic ld_b, ld_h, ld_w, ld_bu, ld_hu, is_load, gr_we;
  logic [3:0] exc;
  logic [31:0] rj_value, rkd_value, alu_result, pc, rd, load_res, final_result, wdata;
  logic [33:0] csr_data;
  logic [4:0] dest;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  logic flush, data_ok_w, ms_ready_go, ms_enter, handoff, load_pending;
  assign {ld_b, ld_h, ld_w, ld_bu, ld_hu, exc, rj_value, rkd_value, csr_data, gr_we, dest, alu_result, pc} = bus_r;
  assign flush = wb_ex | wb_ertn;
  assign data_ok_w = (state == S_WAIT) && data_sram_data_ok;
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign ms_allowin = !cancel && (!ms_valid || (ms_ready_go && ws_allowin));
  assign ms_enter = es_to_ms_valid && ms_allowin;
  assign handoff = ms_to_ws_valid && ws_allowin;
  always_comb begin
    ms_ready_go = (state == S_DONE) || data_ok_w;
    state_nx = flush ? S_IDLE :
               ms_enter ? (es_to_ms_bus[177] ? S_WAIT : S_DONE) :
               handoff ? S_IDLE :
               data_ok_w ? S_DONE : state;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
      ms_valid <= 1'b0;
      cancel <= 1'b0;
      buf_valid <= 1'b0;
    end else begin
      state <= state_nx;
      ms_valid <= flush ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid;
      cancel <= cancel ? !data_sram_data_ok : (flush && ms_valid && state == S_WAIT && !data_sram_data_ok);
      buf_valid <= (flush || handoff) ? 1'b0 : (data_ok_w && ms_valid) ? 1'b1 : buf_valid;
    end
  end
  always_ff @(posedge clk) begin
    if (ms_enter) bus_r <= es_to_ms_bus[176:0];
    if (data_ok_w && !ws_allowin) buf_data <= data_sram_rdata;
  end
  // a response latched during a WB stall keeps the result stable after the bus moves on
  assign rd = buf_valid ? buf_data : data_sram_rdata;
  assign byte_v = rd[{alu_result[1:0], 3'b000} +: 8];
  assign half_v = alu_result[1] ? rd[31:16] : rd[15:0];
  assign is_load = ld_b | ld_h | ld_w | ld_bu | ld_hu;
  assign load_res = ld_w ? rd :
                    (ld_b | ld_bu) ? {{24{ld_b & byte_v[7]}}, byte_v} :
                    {{16{ld_h & half_v[15]}}, half_v};
  assign final_result = (is_load && !(|exc)) ? load_res : alu_result;
  assign ms_to_ws_bus = {exc, rj_value, rkd_value, csr_data, gr_we, dest, final_result, pc};
  assign data_sram_addr_error = alu_result;
  assign ms_ex = ms_valid && ((|exc) || csr_data[30] || csr_data[29]);
`ifdef MS_LOAD_FWD_EN
  assign load_pending = ms_valid && is_load && !(data_ok_w || buf_valid);
  assign wdata = final_result;
`else
  assign load_pending = ms_valid && is_load;
  assign wdata = alu_result;
`endif
  assign ms_fwd_bus = {ms_valid && (|csr_data[33:31]), load_pending, ms_valid, ms_valid && gr_we, dest, wdata};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: per-cycle vector table plus hand sequences for mem_stage (default build)
module tb_mem_stage;
  logic clk = 1'b0, resetn, es_to_ms_valid, ms_allowin, ws_allowin, ms_to_ws_valid;
  logic data_sram_data_ok, wb_ex, wb_ertn, ms_ex;
  logic [177:0] es_to_ms_bus;
  logic [171:0] ms_to_ws_bus;
  logic [31:0] data_sram_rdata, data_sram_addr_error;
  logic [40:0] ms_fwd_bus;
  int n_vec = 0, n_err = 0;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_allowin(ms_allowin), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .data_sram_addr_error(data_sram_addr_error), .wb_ex(wb_ex), .wb_ertn(wb_ertn), .ms_ex(ms_ex),
    .ms_fwd_bus(ms_fwd_bus)
  );
  always #5 clk = ~clk;

  localparam logic [4:0] NL = 5'b00000, LB = 5'b10000, LH = 5'b01000, LW = 5'b00100, LBU = 5'b00010, LHU = 5'b00001;

  typedef struct {
    string nm;
    logic rstn, ev, rs;
    logic [4:0] ld;
    logic [3:0] exc;
    logic [4:0] csrf;
    logic [31:0] alu;
    logic wa, ok;
    logic [31:0] rd;
    logic fl, x_allow, x_v;
    logic [31:0] x_res;
    logic x_ex, x_lp, x_mv;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [177:0] mk(input logic rs, input logic [4:0] ld, input logic [3:0] exc,
                                      input logic [4:0] csrf, input logic [31:0] alu, input logic [31:0] pc);
    return {rs, ld, exc, 32'h11, 32'h22, {csrf, 29'h0}, 1'b1, 5'd7, alu, pc};
  endfunction

  task automatic add(input string nm, input logic rstn, ev, rs, input logic [4:0] ld, input logic [3:0] exc,
                     input logic [4:0] csrf, input logic [31:0] alu, input logic wa, ok, input logic [31:0] rd,
                     input logic fl, x_allow, x_v, input logic [31:0] x_res, input logic x_ex, x_lp, x_mv);
    vec_t v;
    v.nm = nm; v.rstn = rstn; v.ev = ev; v.rs = rs; v.ld = ld; v.exc = exc; v.csrf = csrf; v.alu = alu;
    v.wa = wa; v.ok = ok; v.rd = rd; v.fl = fl; v.x_allow = x_allow; v.x_v = x_v; v.x_res = x_res;
    v.x_ex = x_ex; v.x_lp = x_lp; v.x_mv = x_mv;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input string f, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
    end
  endtask

  initial begin
    //   name            rstn ev rs ld   exc   csrf      alu           wa ok rd            fl  allow v  res            ex lp mv
    add("reset",          0, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("add_in",         1, 1, 0, NL,  4'h0, 5'h00, 32'h55,        1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("add_out",        1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 0, 32'h0,         0,  1, 1, 32'h55,         0, 0, 1);
    add("ldb_in",         1, 1, 1, LB,  4'h0, 5'h00, 32'h1003,      1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("ldb_wait",       1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 0, 32'h0,         0,  0, 0, 32'h0,          0, 1, 1);
    add("ldb_ok",         1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 1, 32'h80FFFF7F,  0,  1, 1, 32'hFFFFFF80,   0, 1, 1);
    add("ldhu_in",        1, 1, 1, LHU, 4'h0, 5'h00, 32'h2002,      1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("ldhu_ok_stall",  1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         0, 1, 32'hBEEF1234,  0,  0, 1, 32'h0000BEEF,   0, 1, 1);
    add("ldhu_hold1",     1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         0, 0, 32'hDEADDEAD,  0,  0, 1, 32'h0000BEEF,   0, 1, 1);
    add("ldhu_hold2",     1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         0, 0, 32'h12345678,  0,  0, 1, 32'h0000BEEF,   0, 1, 1);
    add("ldhu_release",   1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 0, 32'h0,         0,  1, 1, 32'h0000BEEF,   0, 1, 1);
    add("ldh_in",         1, 1, 1, LH,  4'h0, 5'h00, 32'h3000,      1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("ldh_ok_b2b",     1, 1, 1, LBU, 4'h0, 5'h00, 32'h4001,      1, 1, 32'h12348001,  0,  1, 1, 32'hFFFF8001,   0, 1, 1);
    add("ldbu_ok",        1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 1, 32'h0000F000,  0,  1, 1, 32'h000000F0,   0, 1, 1);
    add("st_in",          1, 1, 1, NL,  4'h0, 5'h00, 32'h5000,      1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("st_wait",        1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 0, 32'h0,         0,  0, 0, 32'h0,          0, 0, 1);
    add("st_ok",          1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 1, 32'hFFFFFFFF,  0,  1, 1, 32'h5000,       0, 0, 1);
    add("ldw_in",         1, 1, 1, LW,  4'h0, 5'h00, 32'h6000,      1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("ldw_flush",      1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 0, 32'h0,         1,  0, 0, 32'h0,          0, 1, 1);
    add("cancel_hold",    1, 1, 0, NL,  4'h0, 5'h00, 32'h77,        1, 0, 32'h0,         0,  0, 0, 32'h0,          0, 0, 0);
    add("cancel_ok",      1, 1, 0, NL,  4'h0, 5'h00, 32'h77,        1, 1, 32'hAAAA,      0,  0, 0, 32'h0,          0, 0, 0);
    add("after_cancel",   1, 1, 0, NL,  4'h0, 5'h00, 32'h77,        1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("nl_out",         1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 0, 32'h0,         0,  1, 1, 32'h77,         0, 0, 1);
    add("ldw2_in",        1, 1, 1, LW,  4'h0, 5'h00, 32'h7000,      1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("flush_ok",       1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         0, 1, 32'h1111,      1,  0, 1, 32'h1111,       0, 1, 1);
    add("no_cancel",      1, 1, 0, NL,  4'h0, 5'h00, 32'h88,        1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("nl2_out",        1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 0, 32'h0,         0,  1, 1, 32'h88,         0, 0, 1);
    add("flush_entry",    1, 1, 0, NL,  4'h0, 5'h00, 32'h99,        1, 0, 32'h0,         1,  1, 0, 32'h0,          0, 0, 0);
    add("flushed",        1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("ale_in",         1, 1, 0, LW,  4'h1, 5'h00, 32'h1001,      1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("ale_out",        1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         0, 0, 32'h0,         0,  0, 1, 32'h1001,       1, 1, 1);
    add("ale_go",         1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 0, 32'h0,         0,  1, 1, 32'h1001,       1, 1, 1);
    add("ertn_in",        1, 1, 0, NL,  4'h0, 5'h02, 32'h123,       1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("ertn_out",       1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 0, 32'h0,         0,  1, 1, 32'h123,        1, 0, 1);
    add("ldw3_in",        1, 1, 1, LW,  4'h0, 5'h00, 32'h8000,      1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("ldw3_rst",       0, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 0, 32'h0,         0,  0, 0, 32'h0,          0, 1, 1);
    add("post_rst",       1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 1, 32'h5,         0,  1, 0, 32'h0,          0, 0, 0);
    add("post_rst_in",    1, 1, 0, NL,  4'h0, 5'h00, 32'h42,        1, 0, 32'h0,         0,  1, 0, 32'h0,          0, 0, 0);
    add("post_rst_out",   1, 0, 0, NL,  4'h0, 5'h00, 32'h0,         1, 0, 32'h0,         0,  1, 1, 32'h42,         0, 0, 1);

    resetn = 1'b0; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; wb_ex = 1'b0; wb_ertn = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      resetn = tbl[i].rstn; es_to_ms_valid = tbl[i].ev;
      es_to_ms_bus = mk(tbl[i].rs, tbl[i].ld, tbl[i].exc, tbl[i].csrf, tbl[i].alu, 32'h1c000000 + 32'(i) * 4);
      ws_allowin = tbl[i].wa; data_sram_data_ok = tbl[i].ok; data_sram_rdata = tbl[i].rd; wb_ex = tbl[i].fl;
      #1;
      n_vec++;
      chk(tbl[i].nm, "ms_allowin", 64'(ms_allowin), 64'(tbl[i].x_allow));
      chk(tbl[i].nm, "ms_to_ws_valid", 64'(ms_to_ws_valid), 64'(tbl[i].x_v));
      chk(tbl[i].nm, "ms_ex", 64'(ms_ex), 64'(tbl[i].x_ex));
      chk(tbl[i].nm, "load_pending", 64'(ms_fwd_bus[39]), 64'(tbl[i].x_lp));
      chk(tbl[i].nm, "fwd_valid", 64'(ms_fwd_bus[38]), 64'(tbl[i].x_mv));
      chk(tbl[i].nm, "rf_we", 64'(ms_fwd_bus[37]), 64'(tbl[i].x_mv));
      if (tbl[i].x_v) chk(tbl[i].nm, "final_result", 64'(ms_to_ws_bus[63:32]), 64'(tbl[i].x_res));
      if (tbl[i].x_ex) chk(tbl[i].nm, "addr_error", 64'(data_sram_addr_error), 64'(tbl[i].x_res));
    end

    // add: full output bus packing and forward bus
    @(negedge clk);
    resetn = 1'b1; ws_allowin = 1'b1; data_sram_data_ok = 1'b0; wb_ex = 1'b0;
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1'b0, NL, 4'h0, 5'h00, 32'h55, 32'h1c000100);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1;
    n_vec++;
    chk("add_bus", "ms_to_ws_bus", 64'(ms_to_ws_bus[171:64] == {4'h0, 32'h11, 32'h22, 34'h0, 1'b1, 5'd7}),
        64'd1);
    chk("add_bus", "pc_result", {ms_to_ws_bus[63:32], ms_to_ws_bus[31:0]}, {32'h55, 32'h1c000100});
    chk("add_fwd", "ms_fwd_bus", 64'(ms_fwd_bus), 64'({1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h55}));

    // csrrd: ms_csr forward bit, no exception
    @(negedge clk);
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1'b0, NL, 4'h0, 5'h10, 32'h66, 32'h1c000104);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1;
    n_vec++;
    chk("csr_fwd", "ms_fwd_bus", 64'(ms_fwd_bus), 64'({1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h66}));
    chk("csr_fwd", "ms_ex", 64'(ms_ex), 64'd0);

    // wb_ertn flush of a held, stalled instruction
    @(negedge clk);
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1'b0, NL, 4'h0, 5'h00, 32'h67, 32'h1c000108);
    @(negedge clk);
    es_to_ms_valid = 1'b0; ws_allowin = 1'b0; wb_ertn = 1'b1;
    @(negedge clk);
    wb_ertn = 1'b0;
    #1;
    n_vec++;
    chk("ertn_flush", "fwd_valid", 64'(ms_fwd_bus[38]), 64'd0);
    chk("ertn_flush", "ms_allowin", 64'(ms_allowin), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock; resetn  in  1  synchronous active-low reset.
REQ-002 SHALL have ports: es_to_ms_valid  in  1  EXE holds valid instr; es_to_ms_bus  in  178  {req_sent[177], load_op[176:172]={ld_b,ld_h,ld_w,ld_bu,ld_hu}, exception_op[171:168], rj_value, rkd_value, csr_data[33:0], gr_we, dest[4:0], alu_result, pc}; ms_allowin  out  1  MEM accepts.
REQ-003 SHALL have ports: ws_allowin  in  1; ms_to_ws_valid  out  1; ms_to_ws_bus  out  172  {exception_op, rj_value, rkd_value, csr_data, gr_we, dest, final_result, pc}.
REQ-004 SHALL have ports: data_sram_data_ok  in  1  load/store response; data_sram_rdata  in  32  response data; data_sram_addr_error  out  32  alu_result of held instr.
REQ-005 SHALL have ports: wb_ex  in  1; wb_ertn  in  1  flush; ms_ex  out  1  exception/ertn/syscall in MEM (EXE cancels store); ms_fwd_bus  out  41  {ms_csr, load_pending, ms_valid, rf_we, dest, wdata}.

Function
REQ-006 SHALL hold one instr: ms_valid plus bus register loaded when es_to_ms_valid && ms_allowin.
REQ-007 SHALL use FSM IDLE/WAIT/DONE: enter WAIT if req_sent=1, else DONE; WAIT->DONE on data_sram_data_ok; DONE->IDLE/WAIT/DONE on hand-off per next entry.
REQ-008 ms_ready_go SHALL be 1 in DONE or in WAIT with data_ok this cycle; ms_to_ws_valid = ms_valid && ms_ready_go.
REQ-009 ms_allowin SHALL = !cancel && (!ms_valid || (ms_ready_go && ws_allowin)).
REQ-010 Data_ok arriving while ws_allowin=0 SHALL latch rdata into a 32-bit buffer; forwarded result SHALL use buffer thereafter.
REQ-011 Non-load latency 1 cycle; load latency 1 cycle after data_ok (0 extra if data_ok and ws_allowin coincide).
REQ-012 Load result SHALL select by alu_result[1:0]: ld_b/ld_bu byte at offset, sign/zero-extended; ld_h/ld_hu halfword at offset[1]; ld_w full word; non-load: final_result = alu_result.
REQ-013 Store with req_sent SHALL also wait for data_ok; rdata ignored.
REQ-014 Instr with any exception_op bit SHALL have req_sent=0 and pass through with no wait.
REQ-015 ms_ex SHALL = ms_valid && (|exception_op || ertn || syscall bits of csr_data[33:29]).
REQ-016 wb_ex|wb_ertn SHALL clear ms_valid next cycle, override simultaneous entry, return FSM to IDLE.
REQ-017 Flush while WAIT without same-cycle data_ok SHALL set cancel; next data_ok SHALL be discarded and clear cancel; flush with same-cycle data_ok SHALL not set cancel.
REQ-018 ms_fwd_bus: ms_csr = ms_valid && any csrrd/csrwr/csrxchg; rf_we = ms_valid && gr_we; load_pending per REQ-021.

Reset
REQ-019 resetn=0 at clk edge SHALL clear ms_valid, cancel, buffer valid, FSM to IDLE; ms_to_ws_valid, ms_ex, ms_fwd_bus valid bits 0, ms_allowin 1 next cycle.
REQ-020 Reset mid-WAIT SHALL drop outstanding response without setting cancel.

Configuration
REQ-021 MS_LOAD_FWD_EN defined: load_pending = ms_valid && load && !(data_ok||buffered), wdata = aligned load data once available; undefined: load_pending = ms_valid && load throughout MEM, wdata = alu_result.

Verification
REQ-022 ld_b, alu_result=0x1003, rdata=0x80FF_FF7F, data_ok cycle 2, ws_allowin=1 -> final_result 0xFFFF_FF80, ms_to_ws_valid in cycle of data_ok.
REQ-023 ld_hu offset 2, data_ok while ws_allowin=0 for 3 cycles, rdata=0xBEEF_1234 then changes -> final_result 0x0000_BEEF held, ms_allowin=0 until ws_allowin=1.
REQ-024 add, alu_result=0x55 -> ms_to_ws_valid next cycle, fwd {rf_we=1, wdata=0x55, load_pending=0}.
REQ-025 ld_w in WAIT, wb_ex pulse -> ms_valid 0, ms_allowin 0 until next data_ok, that data_ok not passed, then ms_allowin 1.
REQ-026 ale_detected set, req_sent=0 -> ms_ex=1, no wait, data_sram_addr_error=alu_result; resetn=0 mid-load -> all valids 0 next cycle.
